// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its pipeline register.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JR     = 2'b11;

    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return XLEN'(pc + XLEN'(4));
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic stage register with hold / flush / load; anything not loaded becomes a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] next_instr,
    input  logic [XLEN-1:0] next_pc_plus4,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    // Priority: reset > hold > flush > load > bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (hold) begin
            instr    <= instr;
            pc_plus4 <= pc_plus4;
            valid    <= valid;
        end else if (load && !flush) begin
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
            valid    <= 1'b1;
        end else begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, imem request handshake and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic [1:0]      pc_src_d,
    input  logic [XLEN-1:0] branch_target_d,
    input  logic [XLEN-1:0] jump_target_d,
    input  logic [XLEN-1:0] jr_target_d,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_wait,
    output logic [XLEN-1:0] perf_redirect
`endif
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] redir_pc_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            ifid_load;

    assign redirect   = (pc_src_d != PC_SRC_SEQ) && !stall_d;
    assign imem_addr  = pc_f;
    assign fetch_busy = imem_req && !imem_ready;

    always_comb begin
        target = branch_target_d;
        case (pc_src_d)
            PC_SRC_BRANCH: target = branch_target_d;
            PC_SRC_JUMP:   target = jump_target_d;
            PC_SRC_JR:     target = jr_target_d;
            default:       target = branch_target_d;
        endcase
    end

    // State register; the request flag is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_BOOT;
            imem_req <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next != S_BOOT);
        end
    end

    // Next state: a redirect during an outstanding request must wait it out in S_DROP.
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:  state_next = S_FETCH;
            S_FETCH: if (!imem_ready && redirect) state_next = S_DROP;
            S_DROP:  if (imem_ready) state_next = S_FETCH;
            default: state_next = S_BOOT;
        endcase
    end

    // PC / pending-redirect selection and IF/ID load decision.
    always_comb begin
        pc_next       = pc_f;
        redir_pc_next = redir_pc;
        ifid_load     = 1'b0;
        case (state)
            S_BOOT: begin
                if (redirect) pc_next = target;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_next = target;
                    end else if (!stall_f) begin
                        pc_next   = pc_inc(pc_f);
                        ifid_load = 1'b1;
                    end
                end else if (redirect) begin
                    redir_pc_next = target;
                end
            end
            S_DROP: begin
                if (redirect) redir_pc_next = target;
                if (imem_ready) pc_next = redirect ? target : redir_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f     <= RESET_PC;
            redir_pc <= '0;
        end else begin
            pc_f     <= pc_next;
            redir_pc <= redir_pc_next;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .hold          (stall_d),
        .flush         (redirect),
        .load          (ifid_load),
        .next_instr    (imem_rdata),
        .next_pc_plus4 (pc_inc(pc_f)),
        .instr         (instr_d),
        .pc_plus4      (pc_plus4_d),
        .valid         (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched  <= '0;
            perf_wait     <= '0;
            perf_redirect <= '0;
        end else begin
            if (ifid_load && !stall_d && !redirect) perf_fetched <= XLEN'(perf_fetched + 1'b1);
            if (fetch_busy) perf_wait <= XLEN'(perf_wait + 1'b1);
            if (redirect) perf_redirect <= XLEN'(perf_redirect + 1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage; imem returns its own address as data.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d;
    logic [1:0]  pc_src_d;
    logic [31:0] branch_target_d, jump_target_d, jr_target_d;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_f, instr_d, pc_plus4_d;
    logic        valid_d, fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_wait, perf_redirect;
`endif

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .pc_src_d        (pc_src_d),
        .branch_target_d (branch_target_d),
        .jump_target_d   (jump_target_d),
        .jr_target_d     (jr_target_d),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .pc_f            (pc_f),
        .instr_d         (instr_d),
        .pc_plus4_d      (pc_plus4_d),
        .valid_d         (valid_d),
        .fetch_busy      (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_wait       (perf_wait),
        .perf_redirect   (perf_redirect)
`endif
    );

    typedef struct {
        logic        sf, sd;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic sf, input logic sd, input logic [1:0] src,
                         input logic [31:0] tgt, input logic rdy);
        stall_f         = sf;
        stall_d         = sd;
        pc_src_d        = src;
        branch_target_d = (src == 2'b01) ? tgt : 32'hBAD0_0010;
        jump_target_d   = (src == 2'b10) ? tgt : 32'hBAD0_0020;
        jr_target_d     = (src == 2'b11) ? tgt : 32'hBAD0_0030;
        imem_ready      = rdy;
    endtask

    vec_t vecs[23];

    initial begin
        //            sf    sd    src    tgt           rdy   req   addr          busy  pc            instr         valid
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h4,        32'h0,        1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h8,        32'h4,        1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h8,        1'b0, 32'hC,        32'h8,        1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 32'h100,      1'b1, 1'b1, 32'hC,        1'b0, 32'h100,      32'h0,        1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h100,      1'b0, 32'h104,      32'h100,      1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 32'h20,       1'b1, 1'b1, 32'h104,      1'b0, 32'h20,       32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 1'b1, 32'h20,       1'b1, 32'h20,       32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 1'b1, 32'h20,       1'b1, 32'h20,       32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 1'b1, 32'h20,       1'b1, 32'h20,       32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h20,       1'b0, 32'h24,       32'h20,       1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h40,       1'b1, 1'b1, 32'h24,       1'b0, 32'h40,       32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b0, 2'b10, 32'h200,      1'b0, 1'b1, 32'h40,       1'b1, 32'h40,       32'h0,        1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'b11, 32'h300,      1'b0, 1'b1, 32'h40,       1'b1, 32'h40,       32'h0,        1'b0};
        vecs[14] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h40,       1'b0, 32'h300,      32'h0,        1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h300,      1'b0, 32'h304,      32'h300,      1'b1};
        vecs[16] = '{1'b1, 1'b1, 2'b10, 32'h500,      1'b1, 1'b1, 32'h304,      1'b0, 32'h304,      32'h300,      1'b1};
        vecs[17] = '{1'b1, 1'b1, 2'b10, 32'h500,      1'b1, 1'b1, 32'h304,      1'b0, 32'h304,      32'h300,      1'b1};
        vecs[18] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h304,      1'b0, 32'h308,      32'h304,      1'b1};
        vecs[19] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h308,      1'b0, 32'h30C,      32'h308,      1'b1};
        vecs[20] = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h30C,     1'b0, 32'hFFFF_FFFC, 32'h0,       1'b0};
        vecs[21] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'h0,        32'h0,        1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   -1, 32'(imem_req), 32'h0);
        check("rst_pc",    -1, pc_f,          32'h0);
        check("rst_instr", -1, instr_d,       32'h0);
        check("rst_pc4",   -1, pc_plus4_d,    32'h0);
        check("rst_valid", -1, 32'(valid_d),  32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].sf, vecs[i].sd, vecs[i].src, vecs[i].tgt, vecs[i].rdy);
            #1;
            check("imem_req",   i, 32'(imem_req),   32'(vecs[i].e_req));
            check("imem_addr",  i, imem_addr,       vecs[i].e_addr);
            check("fetch_busy", i, 32'(fetch_busy), 32'(vecs[i].e_busy));
            @(posedge clk);
            #1;
            check("pc_f",    i, pc_f,          vecs[i].e_pc);
            check("instr_d", i, instr_d,       vecs[i].e_instr);
            check("valid_d", i, 32'(valid_d),  32'(vecs[i].e_valid));
            if (vecs[i].e_valid)
                check("pc_plus4_d", i, pc_plus4_d, 32'(vecs[i].e_instr + 32'd4));
            @(negedge clk);
        end

        // Reset while a request is still waiting on imem_ready.
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_req",   100, 32'(imem_req),   32'h0);
        check("midrst_busy",  100, 32'(fetch_busy), 32'h0);
        check("midrst_pc",    100, pc_f,            32'h0);
        check("midrst_instr", 100, instr_d,         32'h0);
        check("midrst_valid", 100, 32'(valid_d),    32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("midrst_perf_fetched",  100, perf_fetched,  32'h0);
        check("midrst_perf_wait",     100, perf_wait,     32'h0);
        check("midrst_perf_redirect", 100, perf_redirect, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("boot_req", 101, 32'(imem_req), 32'h0);
        @(negedge clk);
        #1;
        check("restart_req",  102, 32'(imem_req), 32'h1);
        check("restart_addr", 102, imem_addr,      32'h0);
        @(posedge clk);
        #1;
        check("restart_instr", 103, instr_d,      32'h0);
        check("restart_valid", 103, 32'(valid_d), 32'h1);
        check("restart_pc",    103, pc_f,         32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage pipeline: PC register, next-PC select, instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes stall_f/stall_d from the hazard unit and redirects from the decode stage (branch/jump).
- Produces instr_d/pc_plus4_d for decode.
- Reports imem wait cycles back through fetch_busy so the hazard logic can freeze the pipe.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding injected into the IF/ID register on bubble/flush.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_f  in  1  hold PC; do not accept a returned instruction
- stall_d  in  1  hold IF/ID register; ignore pc_src_d
- pc_src_d  in  2  00 seq, 01 branch taken, 10 jump, 11 jump-register
- branch_target_d  in  32  target for pc_src_d=01
- jump_target_d  in  32  target for pc_src_d=10
- jr_target_d  in  32  target for pc_src_d=11
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc_f)
- imem_rdata  in  32  instruction, valid when imem_ready
- imem_ready  in  1  completes the current request
- pc_f  out  32  current fetch PC
- instr_d  out  32  IF/ID instruction
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  imem_req && !imem_ready

Behaviour:
- Reset values:
  - pc_f=RESET_PC, state=S_BOOT, redir_pc=0.
  - instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0, imem_req=0.
- States:
  - S_BOOT: imem_req=0 for one cycle, then S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc_f.
  - S_DROP: imem_req=1, address held, response will be discarded.
- Redirect: redirect = (pc_src_d!=00) && !stall_d. target is selected by pc_src_d. Arithmetic is 32-bit modulo; PC+4 wraps at 2^32.
- Handshake: while imem_req && !imem_ready, imem_addr must stay stable. Requests are completed, never cancelled.
- S_FETCH, imem_ready=1, no redirect, !stall_f:
  - pc_f<=pc_f+4.
  - If !stall_d, IF/ID loads imem_rdata, pc_f+4, valid=1.
- S_FETCH, imem_ready=1, stall_f=1: data is dropped and pc_f held, so the same address is re-requested the next cycle. imem reads must be side-effect free.
- S_FETCH, imem_ready=0:
  - pc_f held.
  - If !stall_d, IF/ID loads a bubble (NOP_INSTR, valid=0).
- Redirect in S_FETCH with imem_ready=1: pc_f<=target, returned data discarded, IF/ID flushed to bubble. Redirect beats stall_f for the PC.
- Redirect in S_FETCH with imem_ready=0: redir_pc<=target, state<=S_DROP, pc_f unchanged, IF/ID flushed.
- S_DROP:
  - Further redirects overwrite redir_pc (latest wins).
  - On imem_ready: pc_f<=redir_pc (or the new target if a redirect occurs that cycle), data discarded, state<=S_FETCH.
  - IF/ID gets a bubble unless stall_d.
- Priority on IF/ID: reset > stall_d (hold) > redirect flush > load/bubble.
- Reset mid-request: abandon immediately and return to S_BOOT. imem must tolerate the dropped request.
- Latency: instruction at pc_f appears on instr_d the cycle after imem_ready. With single-cycle imem there is one instruction per cycle and a one-bubble redirect penalty.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32), perf_wait (32), perf_redirect (32).
  - perf_fetched increments on each instruction loaded into IF/ID with valid=1.
  - perf_wait increments each fetch_busy cycle.
  - perf_redirect increments on each redirect.
  - All counters clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - PC_SRC_SEQ/BRANCH/JUMP/JR encodings (2-bit).
  - Fetch state encoding S_BOOT/S_FETCH/S_DROP.
  - NOP encoding constant.
- One sub-module, if_id_reg: the IF/ID register with hold/flush/load, reusable for other stage registers.

Test Plan:
- Reset, imem_ready tied 1, rdata=addr: imem_req low for 1 cycle, then addresses 0,4,8. instr_d sequence 0,4,8 with valid_d=1 from cycle 3.
- Branch: pc_src_d=01, branch_target_d=0x100 while pc_f=0x0C → next pc_f=0x100, instr_d=NOP with valid_d=0 for one cycle, then instr 0x100.
- imem_ready low for 3 cycles at 0x20 → imem_addr stable at 0x20, fetch_busy=1 for 3 cycles, three bubbles, then instr 0x20.
- Redirect while waiting: jump to 0x200 at 0x40 during the wait, then second redirect (jr_target_d=0x300) during S_DROP. Data for 0x40 is discarded, next request goes to 0x300.
- stall_f=stall_d=1 for 2 cycles → pc_f and IF/ID frozen, same address re-requested. pc_src_d=10 during the stall is ignored.
- Reset asserted mid-wait → all outputs return to reset values next cycle, restart at RESET_PC. With FETCH_PERF_CNT_EN, counters read 0.
